// File: rtl/avalon_wavetable_reader_pkg.sv
// Shared types and constants for the wavetable reader and its output FIFO.
package avalon_wavetable_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = $clog2(FIFO_DEPTH_DEF) + 1;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/avalon_wavetable_reader_fifo.sv
// Small synchronous FIFO with occupancy count and flush; flush wins over push/pop.
module sync_fifo
  import avalon_wavetable_reader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_wavetable_reader.sv
// Avalon-MM read master streaming a programmable word window (one-shot or looping)
// from on-chip RAM; reads are credit-limited so the output FIFO cannot overflow.
//
//   state    | meaning
//   ST_IDLE  | waiting for start with non-zero length
//   ST_RUN   | issuing reads inside the credit window
//   ST_DRAIN | no new reads; waiting for in-flight beats (and FIFO empty if one-shot)
module avalon_wavetable_reader
  import avalon_wavetable_reader_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, base_q;
  logic [LEN_W-1:0]  len_q, remaining;
  logic              loop_q, aborted, stop_pend, stall_q, done_q;
  logic [CNT_W-1:0]  outstanding, out_nx, fifo_count, fifo_nx;
  logic [CNT_W:0]    credit_used;
  logic              fifo_empty, fifo_full;
  logic              accept, beat, push, pop, flush, credit_ok, stalled, last_word, launch;

  // A word popped this cycle frees its slot before any new request can return data.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok   = credit_used < ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop));

  assign m_read    = (state == ST_RUN) & (stall_q | credit_ok);
  assign stalled   = m_read & m_waitrequest;
  assign accept    = m_read & ~m_waitrequest;
  assign beat      = m_readdatavalid & (outstanding != '0);
  assign push      = beat & ~(state == ST_DRAIN & aborted) & ~fifo_full;
  assign pop       = ~fifo_empty & st_ready;
  assign last_word = (remaining == LEN_W'(1));
  assign launch    = (state == ST_IDLE) & start & (length != '0);

  assign out_nx  = outstanding + CNT_W'(accept) - CNT_W'(beat);
  assign fifo_nx = fifo_count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if ((stop || stop_pend) && !stalled) begin
          state_nx = ST_DRAIN;
          flush    = 1'b1;
        end else if (accept && last_word && !loop_q) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_nx == '0 && (aborted || fifo_nx == '0)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr        <= '0;
      base_q      <= '0;
      len_q       <= '0;
      remaining   <= '0;
      loop_q      <= 1'b0;
      aborted     <= 1'b0;
      stop_pend   <= 1'b0;
      stall_q     <= 1'b0;
      outstanding <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      stall_q     <= stalled;
      done_q      <= (state == ST_DRAIN) && !aborted && (state_nx == ST_IDLE);

      if (launch) begin
        base_q    <= base_addr;
        addr      <= base_addr;
        len_q     <= length;
        remaining <= length;
        loop_q    <= loop;
        aborted   <= 1'b0;
      end

      if (accept) begin
        if (last_word && loop_q) begin
          addr      <= base_q;
          remaining <= len_q;
        end else begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
        end
      end

      // Stop during a stalled request waits for that request to be accepted.
      if (state_nx != ST_RUN)                     stop_pend <= 1'b0;
      else if (state == ST_RUN && stop && stalled) stop_pend <= 1'b1;

      if (state == ST_RUN && state_nx == ST_DRAIN) aborted <= flush;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (m_readdata),
    .pop   (pop),
    .flush (flush),
    .rdata (st_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign busy         = (state != ST_IDLE);
  assign done         = done_q;
  assign m_address    = addr;
  assign m_byteenable = BYTEEN_ALL;
  assign st_valid     = ~fifo_empty;

endmodule

// File: tb/tb_avalon_wavetable_reader.sv
// Directed bench for avalon_wavetable_reader with a latency-configurable RAM model.
module tb_avalon_wavetable_reader;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop, st_ready;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy, done, m_read, st_valid;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [31:0] st_data;

  always #5 clk = ~clk;

  avalon_wavetable_reader dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .base_addr(base_addr), .length(length), .loop(loop),
    .busy(busy), .done(done),
    .m_address(m_address), .m_read(m_read), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  // RAM model: fixed read latency, optional random waitrequest.
  typedef struct { logic [11:0] a; int due; } rq_t;
  rq_t pend[$];
  rq_t rq;
  int  cyc = 0;
  int  ram_lat = 1;
  bit  stall_en = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (m_read && !m_waitrequest) begin
      rq.a = m_address;
      rq.due = cyc + ram_lat - 1;
      pend.push_back(rq);
    end
    m_readdatavalid <= 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      m_readdatavalid <= 1'b1;
      m_readdata <= mem_val(pend[0].a);
      void'(pend.pop_front());
    end
    m_waitrequest <= stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  logic [11:0] acc_q[$];
  logic [31:0] got_q[$];
  int done_cnt = 0, done_fall = 0, done_busy = 0, vld_cnt = 0, hold_viol = 0;
  logic prev_stall = 1'b0, prev_busy = 1'b0;
  logic [11:0] prev_addr = '0;

  always @(negedge clk) begin
    if (m_read && !m_waitrequest) acc_q.push_back(m_address);
    if (st_valid && st_ready) got_q.push_back(st_data);
    if (st_valid) vld_cnt++;
    if (done) done_cnt++;
    if (done && busy) done_busy++;
    if (prev_busy && !busy && done) done_fall++;
    if (prev_stall && (!m_read || m_address != prev_addr)) hold_viol++;
    prev_stall = m_read && m_waitrequest;
    prev_addr  = m_address;
    prev_busy  = busy;
  end

  task automatic clr();
    acc_q.delete();
    got_q.delete();
    done_cnt = 0; done_fall = 0; done_busy = 0; vld_cnt = 0; hold_viol = 0;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(input logic [11:0] b, input logic [12:0] l, input logic lp);
    base_addr = b; length = l; loop = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc, output int n);
    n = 0;
    while (busy && n < max_cyc) begin @(posedge clk); #1; n++; end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic chk_xfer(input string tag, input logic [11:0] b, input int l);
    int ae = 0, de = 0;
    logic [11:0] a;
    chk({tag, "_nacc"}, acc_q.size(), l);
    chk({tag, "_ndat"}, got_q.size(), l);
    for (int i = 0; i < l; i++) begin
      a = b + 12'(i);
      if (i < acc_q.size() && acc_q[i] !== a) ae++;
      if (i < got_q.size() && got_q[i] !== mem_val(a)) de++;
    end
    chk({tag, "_addr_err"}, ae, 0);
    chk({tag, "_data_err"}, de, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, ae, de, nd, v0;
    logic [11:0] a;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; st_ready = 1'b1;
    base_addr = '0; length = '0;
    cyc_wait(3);
    chk("rst_busy", busy, 0);
    chk("rst_mread", m_read, 0);
    chk("rst_valid", st_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", m_address, 0);
    chk("rst_byteen", m_byteenable, 4'hF);
    reset = 1'b0;
    cyc_wait(2);

    // one-shot
    clr();
    go(12'h010, 13'd8, 1'b0);
    chk("os_lat_mread", m_read, 1);
    chk("os_lat_addr", m_address, 12'h010);
    wait_idle("os", 100, n);
    cyc_wait(2);
    chk_xfer("os", 12'h010, 8);
    chk("os_done", done_cnt, 1);
    chk("os_done_at_fall", done_fall, 1);
    chk("os_done_busy", done_busy, 0);

    // back-pressure
    clr();
    st_ready = 1'b0;
    go(12'h100, 13'd16, 1'b0);
    cyc_wait(20);
    chk("bp_nacc", acc_q.size(), 4);
    chk("bp_mread", m_read, 0);
    chk("bp_valid", st_valid, 1);
    chk("bp_data", st_data, mem_val(12'h100));
    st_ready = 1'b1;
    wait_idle("bp", 100, n);
    cyc_wait(2);
    chk_xfer("bp", 12'h100, 16);
    chk("bp_done", done_cnt, 1);

    // random waitrequest
    clr();
    stall_en = 1'b1;
    go(12'h200, 13'd12, 1'b0);
    wait_idle("wr", 400, n);
    stall_en = 1'b0;
    cyc_wait(2);
    chk_xfer("wr", 12'h200, 12);
    chk("wr_hold", hold_viol, 0);
    chk("wr_done", done_cnt, 1);

    // loop with address wrap, then stop
    clr();
    go(12'hFFE, 13'd4, 1'b1);
    k = 0;
    while (acc_q.size() < 10 && k < 50) begin @(posedge clk); #1; k++; end
    chk("lp_acc10", acc_q.size() >= 10, 1);
    chk("lp_ndat", got_q.size() >= 6, 1);
    ae = 0; de = 0;
    for (int i = 0; i < 10; i++) begin
      a = 12'hFFE + 12'(i % 4);
      if (i < acc_q.size() && acc_q[i] !== a) ae++;
      if (i < got_q.size() && got_q[i] !== mem_val(a)) de++;
    end
    chk("lp_addr_err", ae, 0);
    chk("lp_data_err", de, 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("lp_stop_mread", m_read, 0);
    nd = got_q.size();
    wait_idle("lp", 20, n);
    cyc_wait(2);
    chk("lp_discard", got_q.size(), nd);
    chk("lp_valid", st_valid, 0);
    chk("lp_done", done_cnt, 0);

    // zero length
    clr();
    go(12'h123, 13'd0, 1'b0);
    chk("z_busy", busy, 0);
    cyc_wait(3);
    chk("z_nacc", acc_q.size(), 0);
    chk("z_done", done_cnt, 0);

    // start while busy
    clr();
    go(12'h300, 13'd6, 1'b0);
    cyc_wait(1);
    go(12'h500, 13'd2, 1'b1);
    wait_idle("sb", 100, n);
    cyc_wait(2);
    chk_xfer("sb", 12'h300, 6);
    chk("sb_done", done_cnt, 1);

    // full 4096-word window
    clr();
    go(12'h000, 13'd4096, 1'b0);
    wait_idle("full", 5000, n);
    chk("full_tput", n <= 4100, 1);
    cyc_wait(2);
    chk_xfer("full", 12'h000, 4096);
    chk("full_done", done_cnt, 1);

    // reset with reads outstanding
    clr();
    ram_lat = 6;
    go(12'h080, 13'd16, 1'b0);
    k = 0;
    while (acc_q.size() < 3 && k < 30) begin @(posedge clk); #1; k++; end
    chk("rs_pre_nacc", acc_q.size(), 3);
    chk("rs_pre_nvld", vld_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rs_busy", busy, 0);
    chk("rs_mread", m_read, 0);
    chk("rs_valid", st_valid, 0);
    chk("rs_done", done, 0);
    chk("rs_addr", m_address, 0);
    reset = 1'b0;
    v0 = vld_cnt;
    cyc_wait(12);
    chk("rs_late_vld", vld_cnt, v0);
    chk("rs_idle", busy, 0);
    ram_lat = 1;
    clr();
    go(12'h040, 13'd5, 1'b0);
    wait_idle("rs_new", 100, n);
    cyc_wait(2);
    chk_xfer("rs_new", 12'h040, 5);
    chk("rs_new_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_wavetable_reader.md
Name: avalon_wavetable_reader

Overview:
- Avalon-MM read master: the initiator end of the on-chip RAM slave interface.
- Fetches a programmable window of 32-bit words (wavetable/sample buffer) from on-chip memory, one-shot or looping.
- Delivers the words in order on a valid/ready stream toward the audio datapath.
- Pipelined reads; a credit scheme guarantees the internal FIFO never overflows.

Parameters:
- ADDR_W, 12, word address width (4096-word memory).
- DATA_W, 32, data width.
- LEN_W, 13, length field width (1..4096 words).
- FIFO_DEPTH, 4, output FIFO depth; also the maximum in-flight reads. Power of two, ≥2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle abort request.
- base_addr  in  ADDR_W  first word address, sampled on start.
- length  in  LEN_W  word count, sampled on start.
- loop  in  1  1 = wrap to base forever; sampled on start.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a one-shot transfer completes.
- m_address  out  ADDR_W  Avalon word address.
- m_read  out  1  Avalon read request.
- m_byteenable  out  4  constant 4'hF.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  DATA_W  read data.
- m_readdatavalid  in  1  read data valid.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready.

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy, done, m_read, st_valid = 0; m_address = 0; FIFO and counters cleared. Reset mid-transfer drops everything. Returned readdatavalid beats after reset are ignored: outstanding count is 0 and valid beats are discarded when outstanding = 0.
- States:
  - IDLE → RUN on start with length ≠ 0. start with length = 0 is ignored (no done). start while not IDLE is ignored.
  - RUN: issue reads.
  - RUN → DRAIN when the last one-shot address is accepted, or on stop.
  - DRAIN: wait until outstanding = 0; also FIFO empty for one-shot. Then → IDLE.
- Request rule:
  - m_read = (state == RUN) & (fifo_count + outstanding < FIFO_DEPTH).
  - Accept = m_read & ~m_waitrequest.
  - m_address and m_read hold stable while m_waitrequest = 1.
- Address generation:
  - On accept, addr += 1 modulo 2^ADDR_W; remaining -= 1.
  - When remaining reaches 0: if loop, addr ← base and remaining ← length; else stop issuing.
  - A base + length window crossing 2^ADDR_W wraps to 0; this is legal.
- Outstanding counter:
  - +1 on accept, −1 on m_readdatavalid.
  - Simultaneous accept and valid: unchanged.
  - Width log2(FIFO_DEPTH)+1.
- FIFO and stream:
  - Writes on m_readdatavalid (never full, by credit).
  - st_valid = FIFO not empty; pops on st_valid & st_ready.
  - Simultaneous push and pop is allowed.
  - First word latency: start → first m_read is 1 cycle; readdatavalid → st_valid is 1 cycle.
- Stop:
  - In RUN, m_read deasserts the next cycle; an in-progress stalled request is still held until accepted.
  - Returning beats are discarded. FIFO is flushed on entering DRAIN. done is not pulsed.
  - Stop in IDLE is ignored. Stop in DRAIN is ignored.
- done:
  - Pulses the cycle after the last one-shot word is popped, concurrent with busy falling.
  - Never pulses in loop mode.
- Throughput: 1 word/cycle sustained with a 1-cycle-latency slave, st_ready = 1, and FIFO_DEPTH ≥ 2.

Decomposition:
- Shared package: state enum (IDLE, RUN, DRAIN); constant BYTEEN_ALL = 4'hF; clog2-derived width constants.
- One sub-module: sync_fifo (DATA_W, FIFO_DEPTH; push, pop, flush, count, empty, full), reusable elsewhere.
- Behavioural on-chip RAM model for the bench: latency 1, optional random waitrequest.

Test Plan:
- One-shot: base = 0x010, length = 8, loop = 0, st_ready = 1. Expect m_address 0x010..0x017 once; st_data = mem[0x010..0x017] in order; done pulses once; busy low afterwards.
- Back-pressure: st_ready = 0 after start. Expect exactly 4 reads issued (FIFO_DEPTH), then m_read = 0. Release st_ready: all 16 words delivered in order, none lost.
- waitrequest: random 50% stall. Expect m_address/m_read stable during stall; each address accepted exactly once; data correct.
- Loop with wrap: base = 0xFFE, length = 4, loop = 1. Expect address sequence FFE, FFF, 000, 001, FFE, ...; no done. Then stop: m_read falls, in-flight data discarded, busy falls after outstanding = 0, no done.
- Edge cases: start with length = 0 → stays IDLE. start while busy → ignored, transfer unchanged. length = 4096, base = 0 → 4096 words streamed, done once.
- Reset mid-RUN with 3 reads outstanding: all outputs 0 the next cycle. Late readdatavalid beats produce no st_valid. A fresh start works normally.
